// File: rtl/tff_bank_pkg.sv
// Shared constants and helpers for the prescaled T flip-flop bank.
package tff_bank_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_COUNT  = 1'b1;

  localparam int                    DIV_W_DFLT       = 27;
  localparam logic [DIV_W_DFLT-1:0] DIV_DEFAULT_DFLT = 27'd50_000_000;

  // Wide enough for any practical divisor; callers zero-extend into it and truncate back.
  localparam int DIV_FN_W = 64;

  // A divisor of zero behaves as divide-by-one.
  function automatic logic [DIV_FN_W-1:0] div_eff_f(input logic [DIV_FN_W-1:0] div);
    div_eff_f = (div == '0) ? DIV_FN_W'(1) : div;
  endfunction

endpackage

// File: rtl/tff_bank_prescaled_prescaler.sv
// Prescaler for tff_bank_prescaled: a free-running counter that produces a
// registered one-cycle tick every div_eff enabled cycles. The divisor register
// is runtime-loadable. Optional square-wave output under TFF_BANK_SQW_EN.
module prescaler_tick
  import tff_bank_pkg::*;
#(
  parameter int               DIV_W       = DIV_W_DFLT,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(DIV_DEFAULT_DFLT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_in_i,
  input  logic             div_load_i,
  output logic             tick_o
`ifdef TFF_BANK_SQW_EN
  ,
  output logic             sq_o
`endif
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] lim;
  logic             tick_q, tick_d;

  // Next-state for counter, tick and divisor; >= lets a shrunken divisor expire at once.
  always_comb begin
    div_eff = DIV_W'(div_eff_f(DIV_FN_W'(div_q)));
    lim     = div_eff - DIV_W'(1);
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    if (en_i) begin
      if (cnt_q >= lim) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + DIV_W'(1);
      end
    end
    div_d = div_load_i ? div_in_i : div_q;
  end

  // Prescaler state registers; the expiry test above always sees the pre-load divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      div_q  <= DIV_DEFAULT;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      div_q  <= div_d;
    end
  end

  assign tick_o = tick_q;

`ifdef TFF_BANK_SQW_EN
  logic sq_q;

  // Square wave flips on the same edge that raises tick, so it holds while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_q <= 1'b0;
    end else if (tick_d) begin
      sq_q <= ~sq_q;
    end
  end

  assign sq_o = sq_q;
`endif

endmodule

// File: rtl/tff_bank_prescaled.sv
// Bank of WIDTH T flip-flops advanced by a prescaler tick (clock enable, not a
// derived clock). mode 0: independent toggles by t[i]; mode 1: synchronous
// T-chain up-counter enabled by t[0] with a wrap pulse on all-ones -> zero.
// Define TFF_BANK_SQW_EN to add the sq_out square-wave port.
module tff_bank_prescaled
  import tff_bank_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               DIV_W       = DIV_W_DFLT,
  parameter logic [DIV_W-1:0] DIV_DEFAULT = DIV_W'(DIV_DEFAULT_DFLT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  input  logic             mode,
  input  logic [WIDTH-1:0] t,
  input  logic             q_clr,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             wrap
`ifdef TFF_BANK_SQW_EN
  ,
  output logic             sq_out
`endif
);

  logic             tick_w;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] lowm;

  prescaler_tick #(
    .DIV_W      (DIV_W),
    .DIV_DEFAULT(DIV_DEFAULT)
  ) u_pre (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .div_in_i  (div_in),
    .div_load_i(div_load),
    .tick_o    (tick_w)
`ifdef TFF_BANK_SQW_EN
    ,
    .sq_o      (sq_out)
`endif
  );

  // Flip-flop update driven by the registered tick; q_clr swallows any tick in its cycle.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    tgl    = '0;
    lowm   = '0;
    if (mode == MODE_COUNT) begin
      // Chain toggle: bit i flips when t[0] is set and every lower bit is one.
      for (int i = 0; i < WIDTH; i++) begin
        lowm   = (WIDTH'(1) << i) - WIDTH'(1);
        tgl[i] = t[0] && ((q_q & lowm) == lowm);
      end
    end else begin
      tgl = t;
    end
    if (q_clr) begin
      q_d    = '0;
      wrap_d = 1'b0;
    end else if (tick_w) begin
      q_d    = q_q ^ tgl;
      wrap_d = (mode == MODE_COUNT) && t[0] && (&q_q);
    end
  end

  // Output state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign tick = tick_w;
  assign wrap = wrap_q;

endmodule

// File: doc/tff_bank_prescaled.md
Name: tff_bank_prescaled

Overview:
- Parametrised successor to the single divided-clock T flip-flop stage.
- WIDTH T flip-flops advance only on a prescaler tick, which is a clock enable on the single system clock, not a derived clock.
- Runtime-programmable divide ratio.
- Two modes:
  - Mode 0: independent per-bit toggle.
  - Mode 1: synchronous T-chain up-counter with wrap flag.
- Used as a slow blinker/counter source for lab displays.

Parameters:
- WIDTH, 4: number of T flip-flops / counter bits (>=1).
- DIV_W, 27: prescaler counter and divisor width.
- DIV_DEFAULT, 27'd50_000_000: divisor loaded at reset, before any div_load.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset of the whole block.
- en  input  1  prescaler run enable.
- div_in  input  DIV_W  new divisor value.
- div_load  input  1  latch div_in into the divisor register.
- mode  input  1  0 = independent TFFs, 1 = T-chain counter.
- t  input  WIDTH  per-bit toggle enables; mode 1 uses t[0] only, as the count enable.
- q_clr  input  1  synchronous clear of q only; prescaler unaffected.
- q  output  WIDTH  flip-flop states.
- tick  output  1  one-cycle pulse when the prescaler expires.
- wrap  output  1  one-cycle pulse in mode 1 when q rolls from all-ones to zero.

Behaviour:
- Reset (rst=1 at a clk edge): q=0, tick=0, wrap=0, cnt=0, div_reg=DIV_DEFAULT. rst has priority over everything.
- Effective divisor: div_eff = (div_reg==0) ? 1 : div_reg.
- Prescaler:
  - en=1: if cnt >= div_eff-1, then cnt<=0 and tick<=1; else cnt<=cnt+1 and tick<=0.
  - Because the test is >=, shrinking the divisor below the current cnt still ticks on the next enabled cycle.
  - en=0: cnt holds, tick<=0.
  - tick is registered: the first tick after reset with en held high occurs div_eff cycles after reset deassertion.
- div_load=1: div_reg<=div_in on that edge. The prescaler test in the same cycle still uses the old div_reg. cnt is not cleared.
- q updates act on the registered tick, i.e. q changes on the edge after tick is high, giving a 1-cycle latency tick->q. Priority order: rst > q_clr > tick update.
  - Mode 0: q[i] <= q[i] ^ t[i].
  - Mode 1: if t[0], q <= q+1 mod 2^WIDTH (bit i toggles when all lower bits are 1). wrap<=1 on the same edge that q goes from all-ones to 0; otherwise wrap<=0.
  - wrap is never asserted in mode 0.
- q_clr=1: q<=0 and wrap<=0. Any tick in that cycle is consumed without affecting q.
- mode change: takes effect on the next tick; q is not altered by the change itself.
- rst asserted mid-count: everything returns to reset values on that edge, including div_reg back to DIV_DEFAULT.
- All arithmetic is unsigned. cnt is DIV_W bits and never exceeds div_eff-1 except transiently after a divisor shrink.

Optional Feature:
- Macro: TFF_BANK_SQW_EN.
- Defined: adds output port sq_out (1 bit). Reset value 0. Toggles on every tick, giving a 50%-duty square wave of period 2*div_eff cycles while en=1. Holds level when en=0. Unaffected by q_clr.
- Undefined: port and flop absent; all other behaviour identical.

Decomposition:
- Package tff_bank_pkg:
  - MODE_TOGGLE = 1'b0, MODE_COUNT = 1'b1.
  - Default DIV_W and DIV_DEFAULT constants.
  - A function returning div_eff from a divisor value.
- Sub-module prescaler_tick: cnt, div_reg, div_load, en, tick, and the optional sq_out.
- Top level holds the q register, mode logic and wrap.

Test Plan:
- Reset then en=1 with DIV_DEFAULT overridden to 4 -> tick high at cycles 4, 8, 12; q=0 until t is applied.
- div_load with div_in=0, mode 0, t=4'b0101 -> tick every cycle; q alternates 0000/0101 each cycle with 1-cycle lag.
- Mode 1, divisor 2, t[0]=1, WIDTH=4 -> q counts 0..15 every 2 cycles; wrap pulses once at the 15->0 edge.
- Divisor 10, cnt reaches 7, then load div_in=3 -> tick on the next enabled cycle, then every 3 cycles.
- q_clr asserted in the same cycle tick is high, q=1010 -> q=0000 and no toggle; prescaler cadence unchanged. en=0 for 5 cycles -> no ticks; cnt resumes from its held value.
- rst asserted mid-count with div_reg=3 and q=0110 -> next cycle q=0, tick=0, div_reg=DIV_DEFAULT. With TFF_BANK_SQW_EN defined, sq_out=0 after reset and has period 2*div_eff.
